// File: rtl/perm_pkg.sv
// Shared sizing, vector types and FSM states for the permutation address sequencer.
package perm_pkg;
    localparam int LANES  = 16;
    localparam int LANE_W = 32;
    localparam int ADDR_W = 4;
    localparam int BEAT_W = 8;

    typedef logic [LANES*LANE_W-1:0] lane_vec_t;
    typedef logic [LANES*ADDR_W-1:0] addr_vec_t;
    typedef logic [ADDR_W-1:0]       addr_t;
    typedef logic [BEAT_W-1:0]       beat_t;

    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/perm_addr_vec_gen.sv
// Combinational generator of the packed per-lane rotation addresses for one beat.
module perm_addr_vec_gen
    import perm_pkg::*;
(
    input  logic [ADDR_W-1:0]       base,
    input  logic [ADDR_W-1:0]       stride,
    output logic [LANES*ADDR_W-1:0] addr_vec
);
    // The permute stage rotates lane i by its own index, so to land on source lane
    // (base + i*stride) the address carried is base + i*(stride-1), modulo LANES.
    addr_t stride_m1;
    assign stride_m1 = stride - addr_t'(1);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign addr_vec[i*ADDR_W +: ADDR_W] = base + addr_t'(i) * stride_m1;
    end
endmodule

// File: rtl/perm_addr_seq.sv
// Command-driven sequencer that registers each input vector together with its lane addresses.
// Optional build macro PERM_ADDR_SEQ_BIJ_CHECK_EN adds the sticky err_non_bij flag.
module perm_addr_seq
    import perm_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_W-1:0]       cmd_base,
    input  logic [ADDR_W-1:0]       cmd_stride,
    input  logic [ADDR_W-1:0]       cmd_step,
    input  logic [BEAT_W-1:0]       cmd_beats,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in_data,
    output logic                    t_valid,
    input  logic                    t_ready,
    output logic [LANES*LANE_W-1:0] t_data_dat,
    output logic [LANES*ADDR_W-1:0] t_addr_dat,
    output logic                    t_last,
    output logic                    done
`ifdef PERM_ADDR_SEQ_BIJ_CHECK_EN
   ,output logic                    err_non_bij
`endif
);
    state_t    state;
    state_t    next_state;
    addr_t     base_cur;
    addr_t     stride_q;
    addr_t     step_q;
    beat_t     rem;
    logic      zero_done_q;
    addr_vec_t addr_next;
    logic      cmd_fire;
    logic      in_fire;
    logic      out_fire;
    logic      last_in;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = t_valid & t_ready;
    assign last_in  = (rem == beat_t'(1));

    perm_addr_vec_gen u_addr_gen (
        .base     (base_cur),
        .stride   (stride_q),
        .addr_vec (addr_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cmd_fire && cmd_beats != '0) next_state = RUN;
            RUN:     if (in_fire && last_in) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The output register is one deep, so a new beat is taken only when the slot drains this cycle.
    always_comb begin
        cmd_ready = (state == IDLE);
        in_ready  = (state == RUN) && (!t_valid || t_ready);
        done      = zero_done_q | (out_fire & t_last);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_cur    <= '0;
            stride_q    <= '0;
            step_q      <= '0;
            rem         <= '0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= cmd_fire && (cmd_beats == '0);
            if (cmd_fire) begin
                base_cur <= cmd_base;
                stride_q <= cmd_stride;
                step_q   <= cmd_step;
                rem      <= cmd_beats;
            end else if (in_fire) begin
                base_cur <= base_cur + step_q;
                rem      <= rem - beat_t'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t_valid    <= 1'b0;
            t_last     <= 1'b0;
            t_data_dat <= '0;
            t_addr_dat <= '0;
        end else if (in_fire) begin
            t_valid    <= 1'b1;
            t_last     <= last_in;
            t_data_dat <= in_data;
            t_addr_dat <= addr_next;
        end else if (out_fire) begin
            t_valid <= 1'b0;
            t_last  <= 1'b0;
        end
    end

`ifdef PERM_ADDR_SEQ_BIJ_CHECK_EN
    // An even stride maps two output lanes onto the same source lane, so the gather is not a permutation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_non_bij <= 1'b0;
        else if (cmd_fire && !cmd_stride[0] && cmd_beats != '0)
            err_non_bij <= 1'b1;
    end
`endif
endmodule
